collect_usb_core: RTL and testbench
===================================

Name: collect_usb_core

Overview:
- Device-side (collector) protocol core. It is the responder to the console USB core.
- Receives command bags from the console (DCONF, DCONV, CLINK), drives the local config/convert handshakes, and answers with response bags (DTEMP, DATA).
- Announces itself with a DTYPE bag after reset.
- Watches for console keep-alive (CLINK) and flags link loss.
- Sits between the USB bag receiver/transmitter and the collector's ADC config/convert control.

Parameters:
- LINK_TIMEOUT, 32'd15_000_000: clocks without a valid received bag before link_lost asserts (2x the console link period).
- DATA_IDX_MAX, 4'h5: highest legal data_idx; larger received indices are clamped to 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- fs_read  input  1  receiver holds high when a bag is decoded; held until fd_read is seen
- fd_read  output  1  bag consumed; high in READ_DONE until fs_read drops
- read_btype  input  4  bag type of received bag; valid while fs_read is high
- read_didx  input  4  data index carried in a DCONV bag
- fs_conf  output  1  request to config logic; high in CONF_WORK
- fd_conf  input  1  config logic done
- fs_conv  output  1  request to convert logic; high in CONV_WORK
- fd_conv  input  1  convert logic done
- fs_send  output  1  request to transmitter; high in TYPE_SEND, CONF_SEND, CONV_SEND
- fd_send  input  1  transmitter finished bag
- send_btype  output  4  type of bag to transmit
- data_idx  output  4  index of DATA bag being answered
- link_lost  output  1  no valid bag within LINK_TIMEOUT

Behaviour:
- Bag codes, received:
  - DCONF = 4'b0001
  - DCONV = 4'b1001
  - CLINK = 4'b1011
- Bag codes, sent:
  - DTYPE = 4'b1001
  - DTEMP = 4'b1010
  - DATA = 4'b0101
  - INIT = 4'b0000
- Reset values: state = MAIN_IDLE; send_btype = INIT; data_idx = 0; link_lost = 0; link counter = 0; latched btype = INIT.
- All fs_*/fd_* outputs are combinational decodes of the state register, so they are 0 in reset.
- The FSM is one-hot, registered. Reset acts immediately at any point, including mid-handshake, and abandons any transaction.
- State transitions:
  - MAIN_IDLE -> TYPE_SEND (send_btype <= DTYPE on entry). TYPE_SEND holds until fd_send, then -> MAIN_WAIT.
  - MAIN_WAIT: on fs_read, latch read_btype and read_didx, then -> DECODE.
  - DECODE, by latched btype:
    - DCONF -> CONF_WORK
    - DCONV -> CONV_WORK
    - CLINK -> READ_DONE
    - any other code -> READ_DONE (bag dropped; no response, link counter not cleared)
  - CONF_WORK holds until fd_conf, then -> CONF_SEND (send_btype <= DTEMP). CONF_SEND holds until fd_send, then -> READ_DONE.
  - CONV_WORK holds until fd_conv, then -> CONV_SEND (send_btype <= DATA). CONV_SEND holds until fd_send, then -> READ_DONE.
  - READ_DONE: fd_read = 1; -> MAIN_WAIT when fs_read = 0.
  - Undefined state -> MAIN_IDLE.
- data_idx: loaded in DECODE when the btype is DCONV. Value is read_didx if <= DATA_IDX_MAX, else 0. Otherwise held.
- send_btype: holds its last value outside the load points above.
- Latency: with fs_read high in MAIN_WAIT at edge N, the FSM is in DECODE after N and fs_conf/fs_conv rises after edge N+1. fs_send rises one clock after fd_conf/fd_conv is sampled.
- fd_send and fd_conf/fd_conv are sampled only in their own wait states; pulses in other states are ignored.
- fs_read pulses arriving while busy are not queued. The receiver must hold fs_read until fd_read.
- Link counter:
  - Increments every clock outside reset.
  - Clears to 0 in DECODE when the latched btype is DCONF, DCONV or CLINK.
  - At LINK_TIMEOUT-1 it saturates and link_lost <= 1.
  - link_lost clears on the same valid-decode condition.
  - If the clear and the saturate happen on the same clock, the clear wins.
- link_lost does not alter the FSM; commands are still served.

Test Plan:
- Reset release -> send_btype = 4'b1001 and fs_send = 1 in the 2nd cycle. fd_send pulse -> fs_send = 0 and state MAIN_WAIT. fd_read = 0 throughout.
- fs_read = 1 with btype 4'b0001 -> fs_conf rises 2 clocks later. fd_conf -> fs_send with send_btype = 4'b1010. fd_send -> fd_read = 1 until fs_read drops, then fd_read = 0.
- DCONV with read_didx = 3 -> fs_conv, then DATA bag with data_idx = 3. Repeat with read_didx = 9 -> data_idx = 0.
- Bag 4'b1111 -> no fs_conf/fs_conv/fs_send, fd_read handshake completes, link counter not cleared. Bag 4'b1011 -> counter cleared, no send.
- LINK_TIMEOUT = 100, no bags -> link_lost = 1 at cycle 100 and stays high. CLINK bag -> link_lost = 0 one clock after DECODE.
- Assert rst during CONV_WORK with fs_conv = 1 -> all outputs reset immediately. After release, a new DTYPE bag is sent.

Source files
------------

// File: rtl/collect_usb_core.sv
// collect_usb_core -- collector-side protocol responder for the console USB core.
//
// Announces itself with a DTYPE bag after reset, then serves command bags
// from the console: DCONF runs the local config handshake and answers with
// DTEMP, DCONV runs the convert handshake and answers with a DATA bag for the
// requested index, CLINK is a keep-alive only. A free-running link counter
// flags link_lost when no valid bag has been decoded for LINK_TIMEOUT clocks.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   fs_read / fd_read   receiver handshake (bag decoded / bag consumed)
//   read_btype          received bag type, valid while fs_read is high
//   read_didx           data index carried by a DCONV bag
//   fs_conf / fd_conf   config logic request / done
//   fs_conv / fd_conv   convert logic request / done
//   fs_send / fd_send   transmitter request / done
//   send_btype          type of bag to transmit
//   data_idx            index of the DATA bag being answered
//   link_lost           no valid bag within LINK_TIMEOUT clocks
module collect_usb_core #(
  parameter logic [31:0] LINK_TIMEOUT = 32'd15_000_000,
  parameter logic [3:0]  DATA_IDX_MAX = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fs_read,
  output logic       fd_read,
  input  logic [3:0] read_btype,
  input  logic [3:0] read_didx,
  output logic       fs_conf,
  input  logic       fd_conf,
  output logic       fs_conv,
  input  logic       fd_conv,
  output logic       fs_send,
  input  logic       fd_send,
  output logic [3:0] send_btype,
  output logic [3:0] data_idx,
  output logic       link_lost
);

  // Received bag codes
  localparam logic [3:0] BT_DCONF = 4'b0001;
  localparam logic [3:0] BT_DCONV = 4'b1001;
  localparam logic [3:0] BT_CLINK = 4'b1011;
  // Sent bag codes
  localparam logic [3:0] BT_DTYPE = 4'b1001;
  localparam logic [3:0] BT_DTEMP = 4'b1010;
  localparam logic [3:0] BT_DATA  = 4'b0101;
  localparam logic [3:0] BT_INIT  = 4'b0000;

  typedef enum logic [8:0] {
    MAIN_IDLE = 9'b000000001,
    TYPE_SEND = 9'b000000010,
    MAIN_WAIT = 9'b000000100,
    DECODE    = 9'b000001000,
    CONF_WORK = 9'b000010000,
    CONF_SEND = 9'b000100000,
    CONV_WORK = 9'b001000000,
    CONV_SEND = 9'b010000000,
    READ_DONE = 9'b100000000
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  btype_q;
  logic [3:0]  didx_q;
  logic [31:0] link_cnt;
  logic        valid_decode;

  // A decoded bag counts as link activity only if its type is recognised.
  assign valid_decode = (state == DECODE) &&
                        ((btype_q == BT_DCONF) || (btype_q == BT_DCONV) ||
                         (btype_q == BT_CLINK));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MAIN_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake decodes
  always_comb begin
    state_nxt = state;
    fd_read   = 1'b0;
    fs_conf   = 1'b0;
    fs_conv   = 1'b0;
    fs_send   = 1'b0;
    unique case (state)
      MAIN_IDLE: state_nxt = TYPE_SEND;
      TYPE_SEND: begin
        fs_send = 1'b1;
        if (fd_send) state_nxt = MAIN_WAIT;
      end
      MAIN_WAIT: if (fs_read) state_nxt = DECODE;
      DECODE: begin
        if (btype_q == BT_DCONF)      state_nxt = CONF_WORK;
        else if (btype_q == BT_DCONV) state_nxt = CONV_WORK;
        else                          state_nxt = READ_DONE;
      end
      CONF_WORK: begin
        fs_conf = 1'b1;
        if (fd_conf) state_nxt = CONF_SEND;
      end
      CONF_SEND: begin
        fs_send = 1'b1;
        if (fd_send) state_nxt = READ_DONE;
      end
      CONV_WORK: begin
        fs_conv = 1'b1;
        if (fd_conv) state_nxt = CONV_SEND;
      end
      CONV_SEND: begin
        fs_send = 1'b1;
        if (fd_send) state_nxt = READ_DONE;
      end
      READ_DONE: begin
        fd_read = 1'b1;
        if (!fs_read) state_nxt = MAIN_WAIT;
      end
      default: state_nxt = MAIN_IDLE;
    endcase
  end

  // Received bag latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btype_q <= BT_INIT;
      didx_q  <= '0;
    end else if ((state == MAIN_WAIT) && fs_read) begin
      btype_q <= read_btype;
      didx_q  <= read_didx;
    end
  end

  // Response bag type, loaded on entry to each send state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_btype <= BT_INIT;
    end else begin
      if (state == MAIN_IDLE)                 send_btype <= BT_DTYPE;
      else if ((state == CONF_WORK) && fd_conf) send_btype <= BT_DTEMP;
      else if ((state == CONV_WORK) && fd_conv) send_btype <= BT_DATA;
    end
  end

  // DATA index, out-of-range requests fold to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_idx <= '0;
    end else if ((state == DECODE) && (btype_q == BT_DCONV)) begin
      data_idx <= (didx_q > DATA_IDX_MAX) ? '0 : didx_q;
    end
  end

  // Link watchdog; a valid decode takes priority over saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_cnt  <= '0;
      link_lost <= 1'b0;
    end else if (valid_decode) begin
      link_cnt  <= '0;
      link_lost <= 1'b0;
    end else if (link_cnt >= LINK_TIMEOUT - 32'd1) begin
      link_cnt  <= LINK_TIMEOUT - 32'd1;
      link_lost <= 1'b1;
    end else begin
      link_cnt  <= link_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_collect_usb_core.sv
// Self-checking bench for collect_usb_core: directed startup, link timeout and
// mid-handshake reset, followed by randomized command bags with random
// handshake delays and stray done pulses, checked against a transaction-level
// model of the responder and a cycles-since-last-valid-bag link model.
module tb_collect_usb_core;

  localparam logic [31:0] LT      = 32'd100;
  localparam logic [3:0]  IDX_MAX = 4'h5;

  localparam logic [3:0] DCONF = 4'b0001;
  localparam logic [3:0] DCONV = 4'b1001;
  localparam logic [3:0] CLINK = 4'b1011;
  localparam logic [3:0] DTYPE = 4'b1001;
  localparam logic [3:0] DTEMP = 4'b1010;
  localparam logic [3:0] DATA  = 4'b0101;
  localparam logic [3:0] INIT  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs_read = 1'b0;
  logic       fd_read;
  logic [3:0] read_btype = '0;
  logic [3:0] read_didx = '0;
  logic       fs_conf;
  logic       fd_conf = 1'b0;
  logic       fs_conv;
  logic       fd_conv = 1'b0;
  logic       fs_send;
  logic       fd_send = 1'b0;
  logic [3:0] send_btype;
  logic [3:0] data_idx;
  logic       link_lost;

  collect_usb_core #(.LINK_TIMEOUT(LT), .DATA_IDX_MAX(IDX_MAX)) dut (
    .clk(clk), .rst(rst),
    .fs_read(fs_read), .fd_read(fd_read),
    .read_btype(read_btype), .read_didx(read_didx),
    .fs_conf(fs_conf), .fd_conf(fd_conf),
    .fs_conv(fs_conv), .fd_conv(fd_conv),
    .fs_send(fs_send), .fd_send(fd_send),
    .send_btype(send_btype), .data_idx(data_idx),
    .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edge count since reset release; link model clears at a known future edge.
  int unsigned cyc = 0;
  int unsigned prev_clear = 0;
  int unsigned pend_clear = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_clear = 0;
    end else begin
      if (cyc >= pend_clear) prev_clear = pend_clear;
      check("link_lost", 32'(link_lost), 32'((cyc - prev_clear) >= LT));
    end
  end

  // Model of held output registers
  logic [3:0] mdl_idx;
  logic [3:0] mdl_sbt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_valid(input logic [3:0] bt);
    return (bt == DCONF) || (bt == DCONV) || (bt == CLINK);
  endfunction

  // Assert reset (asynchronously), check reset values, release, serve DTYPE.
  task automatic do_reset();
    int unsigned n;
    rst = 1'b1;
    fs_read = 1'b0; fd_conf = 1'b0; fd_conv = 1'b0; fd_send = 1'b0;
    pend_clear = 0;
    #1;
    check("rst_fs_conf", 32'(fs_conf), 32'd0);
    check("rst_fs_conv", 32'(fs_conv), 32'd0);
    check("rst_fs_send", 32'(fs_send), 32'd0);
    check("rst_fd_read", 32'(fd_read), 32'd0);
    check("rst_send_btype", 32'(send_btype), 32'(INIT));
    check("rst_data_idx", 32'(data_idx), 32'd0);
    check("rst_link_lost", 32'(link_lost), 32'd0);
    mdl_idx = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    tick();
    mdl_sbt = DTYPE;
    check("start_fs_send", 32'(fs_send), 32'd1);
    check("start_send_btype", 32'(send_btype), 32'(mdl_sbt));
    check("start_fd_read", 32'(fd_read), 32'd0);
    n = $urandom_range(0, 3);
    repeat (n) begin
      tick();
      check("start_hold_fs_send", 32'(fs_send), 32'd1);
      check("start_fd_read", 32'(fd_read), 32'd0);
    end
    fd_send = 1'b1;
    tick();
    fd_send = 1'b0;
    check("start_done_fs_send", 32'(fs_send), 32'd0);
    check("start_done_fd_read", 32'(fd_read), 32'd0);
  endtask

  // One full bag transaction; must start with the DUT in MAIN_WAIT.
  task automatic bag(input logic [3:0] bt, input logic [3:0] di);
    int unsigned n;
    fs_read = 1'b1;
    read_btype = bt;
    read_didx = di;
    if (is_valid(bt)) pend_clear = cyc + 2;
    tick();  // DECODE
    check("dec_fs_conf", 32'(fs_conf), 32'd0);
    check("dec_fs_conv", 32'(fs_conv), 32'd0);
    check("dec_fs_send", 32'(fs_send), 32'd0);
    check("dec_fd_read", 32'(fd_read), 32'd0);
    read_btype = 4'($urandom);
    read_didx = 4'($urandom);
    tick();
    if (bt == DCONF || bt == DCONV) begin
      if (bt == DCONV) mdl_idx = (di <= IDX_MAX) ? di : 4'd0;
      n = $urandom_range(0, 4);
      repeat (n + 1) begin
        check("work_fs_conf", 32'(fs_conf), 32'(bt == DCONF));
        check("work_fs_conv", 32'(fs_conv), 32'(bt == DCONV));
        check("work_fs_send", 32'(fs_send), 32'd0);
        if (n > 0) begin
          // stray pulses that belong to other states must be ignored
          fd_send = 1'($urandom);
          if (bt == DCONF) fd_conv = 1'($urandom);
          else             fd_conf = 1'($urandom);
          tick();
          fd_send = 1'b0; fd_conf = 1'b0; fd_conv = 1'b0;
          n--;
        end
      end
      if (bt == DCONF) fd_conf = 1'b1;
      else             fd_conv = 1'b1;
      tick();
      fd_conf = 1'b0; fd_conv = 1'b0;
      mdl_sbt = (bt == DCONF) ? DTEMP : DATA;
      n = $urandom_range(0, 3);
      repeat (n + 1) begin
        check("send_fs_send", 32'(fs_send), 32'd1);
        check("send_fs_conf", 32'(fs_conf), 32'd0);
        check("send_fs_conv", 32'(fs_conv), 32'd0);
        check("send_btype", 32'(send_btype), 32'(mdl_sbt));
        check("send_data_idx", 32'(data_idx), 32'(mdl_idx));
        if (n > 0) begin
          fd_conf = 1'($urandom);
          fd_conv = 1'($urandom);
          tick();
          fd_conf = 1'b0; fd_conv = 1'b0;
          n--;
        end
      end
      fd_send = 1'b1;
      tick();
      fd_send = 1'b0;
    end
    // READ_DONE
    n = $urandom_range(0, 3);
    repeat (n + 1) begin
      check("done_fd_read", 32'(fd_read), 32'd1);
      check("done_fs_send", 32'(fs_send), 32'd0);
      check("done_fs_conf", 32'(fs_conf), 32'd0);
      check("done_fs_conv", 32'(fs_conv), 32'd0);
      if (n > 0) begin
        fd_send = 1'($urandom);
        tick();
        fd_send = 1'b0;
        n--;
      end
    end
    fs_read = 1'b0;
    tick();  // MAIN_WAIT
    check("idle_fd_read", 32'(fd_read), 32'd0);
    check("idle_fs_send", 32'(fs_send), 32'd0);
    check("hold_send_btype", 32'(send_btype), 32'(mdl_sbt));
    check("hold_data_idx", 32'(data_idx), 32'(mdl_idx));
  endtask

  logic [3:0] bt_r, di_r;
  int unsigned k;

  initial begin
    rst = 1'b0;
    #2;
    do_reset();

    // Directed command bags
    bag(DCONF, 4'd0);
    bag(DCONV, 4'd3);
    bag(DCONV, 4'd9);
    bag(DCONV, 4'd5);
    bag(DCONV, 4'd6);
    bag(4'b1111, 4'd2);
    bag(CLINK, 4'd0);

    // Link timeout: no bags, then an unrecognised bag, then keep-alive
    repeat (120) tick();
    check("timeout_link_lost", 32'(link_lost), 32'd1);
    bag(4'b1111, 4'd0);
    check("invalid_keeps_lost", 32'(link_lost), 32'd1);
    bag(CLINK, 4'd0);
    check("clink_clears_lost", 32'(link_lost), 32'd0);

    // Reset in the middle of a convert handshake
    fs_read = 1'b1;
    read_btype = DCONV;
    read_didx = 4'd2;
    pend_clear = cyc + 2;
    tick();
    tick();
    check("pre_rst_fs_conv", 32'(fs_conv), 32'd1);
    #2;
    do_reset();

    // Randomized bags with occasional long silences
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0: bt_r = DCONF;
        1: bt_r = DCONV;
        2: bt_r = CLINK;
        default: begin
          bt_r = 4'($urandom);
          if (is_valid(bt_r)) bt_r = 4'b0110;
        end
      endcase
      di_r = 4'($urandom);
      bag(bt_r, di_r);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(90, 130)) tick();
      else                           repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
